// File: rtl/spike_event_collector.sv
// Buffers nonzero spike vectors in a small FIFO and serializes each set bit
// as a 1-based address event, lowest index first, on a valid/ready port.
module spike_event_collector #(
    parameter int P_N     = 5,
    parameter int P_AW    = 3,
    parameter int P_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       w_rst,
    input  logic [P_N:1]               i_spike,
    input  logic                       i_event_ready,
    input  logic                       i_clr_ovf,
    output logic                       o_event_valid,
    output logic [P_AW-1:0]            o_event_addr,
    output logic                       o_overflow,
    output logic                       o_busy,
    output logic [$clog2(P_DEPTH):0]   o_level
);

    localparam int LW = $clog2(P_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    // Handshake: an event transfers on any edge where o_event_valid and
    // i_event_ready are both high; valid/addr hold steady until that edge.

    logic [0:0]      r_state;
    logic [P_N:1]    r_pend;
    logic [P_N:1]    r_mem [P_DEPTH];
    logic [LW-1:0]   r_wptr;
    logic [LW-1:0]   r_rptr;
    logic [LW:0]     r_level;
    logic            r_ovf;

    logic            w_empty;
    logic            w_full;
    logic            w_accept;
    logic [P_N:1]    w_pend_rest;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [P_AW-1:0] w_addr;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == (LW+1)'(P_DEPTH));
    assign w_accept    = (r_state == S_EMIT) & i_event_ready;
    // Clears the lowest set bit, i.e. the event currently being offered.
    assign w_pend_rest = r_pend & (r_pend - P_N'(1));
    assign w_pop       = ~w_empty & ((r_state == S_IDLE) | (w_accept & (w_pend_rest == '0)));
    assign w_push      = (|i_spike) & (~w_full | w_pop);
    assign w_drop      = (|i_spike) & w_full & ~w_pop;

    always_comb begin
        w_addr = '0;
        for (int i = P_N; i >= 1; i--) begin
            if (r_pend[i]) w_addr = P_AW'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_spike;
    end

    always_ff @(posedge i_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + LW'(1);
            if (w_pop)  r_rptr <= r_rptr + LW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (LW+1)'(1);
                2'b01:   r_level <= r_level - (LW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_pend  <= r_mem[r_rptr];
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_accept) begin
                        if (w_pend_rest != '0) begin
                            r_pend <= w_pend_rest;
                        end else if (w_pop) begin
                            r_pend <= r_mem[r_rptr];
                        end else begin
                            r_pend  <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_pend  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge i_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_event_valid = (r_state == S_EMIT);
    assign o_event_addr  = (r_state == S_EMIT) ? w_addr : '0;
    assign o_overflow    = r_ovf;
    assign o_busy        = (r_state != S_IDLE) | ~w_empty;
    assign o_level       = r_level;

endmodule

// File: doc/spike_event_collector.md
# spike_event_collector

Receive-side companion of the spike pulse generator. Captures the one-cycle, P_N-bit spike vectors the generator emits and buffers them in a small vector FIFO. Serializes every set bit into an address-event (1-based neuron index) on a valid/ready interface. It sits between the input spike layer and the ODESA neuron arbitration logic, so simultaneous spikes are delivered one at a time and never lost silently.

## Interface
- P_N, 5, width of incoming spike vector (bits numbered P_N..1)
- P_AW, 3, event address width; must satisfy 2^P_AW > P_N
- P_DEPTH, 4, FIFO depth in vectors; power of two, ≥2
- i_clk  input  1  clock, all logic on rising edge
- w_rst  input  1  reset, asynchronous, active-low
- i_spike  input  [P_N:1]  one-cycle spike vector; all-zero means no spike
- i_event_ready  input  1  downstream accepts current event
- i_clr_ovf  input  1  synchronous clear of o_overflow
- o_event_valid  output  1  event address valid
- o_event_addr  output  [P_AW-1:0]  1-based index of the spiking bit; 0 when not valid
- o_overflow  output  1  sticky: a nonzero vector was dropped
- o_busy  output  1  FIFO non-empty or serializer not idle
- o_level  output  [clog2(P_DEPTH):0]  FIFO occupancy, 0..P_DEPTH

## Operation
- Capture: on each edge where i_spike != 0, push the vector into the FIFO. Zero vectors are never pushed.
- Full: if the FIFO is full and no pop occurs on the same edge, the vector is dropped and o_overflow is set. A push and pop on the same edge while full is accepted; level is unchanged.
- Serializer FSM, held in working register r_pend[P_N:1]:
  - IDLE: if the FIFO is non-empty, pop the head into r_pend and go to EMIT.
  - EMIT: o_event_valid=1; o_event_addr = position of the lowest set bit of r_pend (bit 1 → addr 1).
    - On valid & ready, clear that bit.
    - If r_pend still has bits set, stay in EMIT.
    - Else if the FIFO is non-empty, pop the next vector into r_pend on the same edge and stay in EMIT (no bubble).
    - Else go to IDLE.
- Ordering: vectors leave in FIFO order. Within a vector, bits leave in ascending index order.
- o_event_valid and o_event_addr stay stable while ready is low (AXI-style; valid never drops without acceptance).
- o_overflow: set wins over i_clr_ovf when both occur on the same edge. Otherwise i_clr_ovf clears it.
- o_busy = (state != IDLE) | (level != 0).
- Arithmetic: FIFO pointers are clog2(P_DEPTH) bits and wrap modulo P_DEPTH. Level is one bit wider. Full = (level == P_DEPTH).

## Timing
- Reset (w_rst low, async): state IDLE, r_pend=0, FIFO empty, pointers 0. Outputs o_event_valid=0, o_event_addr=0, o_overflow=0, o_busy=0, o_level=0.
- Latency: a vector sampled at edge t0 is written at t0. IDLE pops it at t0+1. o_event_valid rises after t0+1.
- A vector with k set bits and ready held high occupies exactly k EMIT cycles.
- Consecutive FIFO vectors with ready high stream with no idle cycle.
- Reset asserted mid-EMIT: the pending event and all buffered vectors are discarded immediately. After release, valid stays low until a new spike arrives.
- i_spike is sampled on every edge regardless of FSM state. Capture is independent of serialization.

## Test plan
- Single spike: i_spike=5'b00100 for one cycle, ready=1 → valid one cycle later with addr=3 for 1 cycle, then idle; o_level 1→0.
- Multi-bit: i_spike=5'b10011, ready=1 → addrs 1, 2, 5 on consecutive cycles, then valid=0.
- Backpressure: i_spike=5'b01010, ready=0 for 4 cycles then 1 → addr=2 held stable while ready low, then 2 then 4.
- Overflow: ready=0, push 5 nonzero vectors (P_DEPTH=4); first popped into r_pend, so 5th fills the FIFO to 4 and a 6th sets o_overflow=1 with o_level=4. Then i_clr_ovf=1 → o_overflow=0. Simultaneous clear and overflow → stays 1.
- Back-to-back: vectors 5'b00001, 5'b00010, 5'b00100 on consecutive cycles, ready=1 → addrs 1, 2, 3 with no gap.
- Reset mid-operation: vector 5'b11111, ready=1, assert w_rst after addr=2 is accepted → all outputs 0 asynchronously; no further events after release.
